// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: fetch-side next-address resolver with a 2-bit BHT.
// Decodes I for unconditional jumps, predicts conditionals, tracks one branch.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   I, PC              fetched instruction and its fall-through address
//   enable             I is a conditional jump
//   predict_taken      table prediction for I (0 when enable=0)
//   next               next fetch address
//   stall              conditional present while a branch is still unresolved
//   res_valid/taken    resolution of the in-flight branch from execute
//   mispredict         registered one-cycle pulse on a wrong prediction
//   recover_addr       registered correct address, valid with mispredict
module branch_predictor_bht #(
   parameter int          INSTR_W  = 22,
   parameter int          ADDR_W   = 11,
   parameter int          IDX_W    = 4,
   parameter logic [2:0]  JMP_OPC  = 3'b100,
   parameter logic [1:0]  CNT_INIT = 2'b01
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INSTR_W-1:0] I,
   input  logic [ADDR_W-1:0] PC,
   output logic              enable,
   output logic              predict_taken,
   output logic [ADDR_W-1:0] next,
   output logic              stall,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              mispredict,
   output logic [ADDR_W-1:0] recover_addr
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [1:0]        cnt [DEPTH];
   logic              pend_v;
   logic [IDX_W-1:0]  pend_idx;
   logic              pend_pred;
   logic [ADDR_W-1:0] pend_target;
   logic [ADDR_W-1:0] pend_fall;

   logic [2:0]        opc;
   logic              msb;
   logic              is_jmp;
   logic [IDX_W-1:0]  idx;
   logic [ADDR_W-1:0] target;
   logic              accept;
   logic              resolve;
   logic              unused_bits;

   assign opc         = I[INSTR_W-1:INSTR_W-3];
   assign msb         = I[INSTR_W-1];
   assign is_jmp      = msb & (opc == JMP_OPC);
   assign idx         = PC[IDX_W-1:0];
   assign target      = I[ADDR_W-1:0];
   assign unused_bits = ^I[INSTR_W-4:ADDR_W];

   assign enable        = msb & ~is_jmp;
   assign predict_taken = enable & cnt[idx][1];
   assign stall         = enable & pend_v & ~res_valid;
   assign accept        = enable & ~stall;
   assign resolve       = res_valid & pend_v;

   always_comb begin
      next = PC;
      unique case (1'b1)
         is_jmp:  next = target;
         enable:  next = predict_taken ? target : PC;
         default: next = PC;
      endcase
   end

   // Table update targets the pending index; a same-cycle accept reads
   // the pre-update value because the read above is purely combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            cnt[i] <= CNT_INIT;
      end else if (resolve) begin
         if (res_taken) begin
            if (cnt[pend_idx] != 2'b11)
               cnt[pend_idx] <= cnt[pend_idx] + 2'd1;
         end else begin
            if (cnt[pend_idx] != 2'b00)
               cnt[pend_idx] <= cnt[pend_idx] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v      <= 1'b0;
         pend_idx    <= '0;
         pend_pred   <= 1'b0;
         pend_target <= '0;
         pend_fall   <= '0;
      end else if (accept) begin
         pend_v      <= 1'b1;
         pend_idx    <= idx;
         pend_pred   <= predict_taken;
         pend_target <= target;
         pend_fall   <= PC;
      end else if (resolve) begin
         pend_v      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict   <= 1'b0;
         recover_addr <= '0;
      end else begin
         mispredict <= resolve & (res_taken != pend_pred);
         if (resolve)
            recover_addr <= res_taken ? pend_target : pend_fall;
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: directed checks of decode, prediction, stall,
// saturation, mispredict recovery and asynchronous reset.
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst_n;
   logic [21:0] I;
   logic [10:0] PC;
   logic        enable;
   logic        predict_taken;
   logic [10:0] next;
   logic        stall;
   logic        res_valid;
   logic        res_taken;
   logic        mispredict;
   logic [10:0] recover_addr;

   int n_run;
   int n_fail;

   branch_predictor_bht dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .I             (I),
      .PC            (PC),
      .enable        (enable),
      .predict_taken (predict_taken),
      .next          (next),
      .stall         (stall),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .mispredict    (mispredict),
      .recover_addr  (recover_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cond(input logic [10:0] pc, input logic [10:0] tgt);
      I  = {3'b101, 8'h00, tgt};
      PC = pc;
   endtask

   task automatic set_idle();
      I  = 22'h0;
      PC = 11'h7F0;
   endtask

   // Accept a conditional, resolve it on the next cycle, check the outcome.
   task automatic branch(input string tag, input logic [10:0] pc,
                         input logic [10:0] tgt, input logic taken,
                         input logic exp_pred);
      set_cond(pc, tgt);
      res_valid = 1'b0;
      #1;
      check({tag, "_pred"}, predict_taken, exp_pred);
      tick();
      set_idle();
      res_valid = 1'b1;
      res_taken = taken;
      tick();
      res_valid = 1'b0;
      check({tag, "_misp"}, mispredict, taken != exp_pred);
      if (taken != exp_pred)
         check({tag, "_rec"}, recover_addr, taken ? tgt : pc);
      tick();
   endtask

   initial begin
      n_run     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      res_valid = 1'b0;
      res_taken = 1'b0;
      I         = 22'h00123;
      PC        = 11'h045;
      #1;
      check("rst_en", enable, 0);
      check("rst_next", next, 11'h045);
      check("rst_stall", stall, 0);
      check("rst_pred", predict_taken, 0);
      check("rst_misp", mispredict, 0);
      check("rst_rec", recover_addr, 0);
      tick();
      tick();
      rst_n = 1'b1;

      // Unconditional jump: target redirect, no pending capture.
      I  = {3'b100, 8'hFF, 11'h3A7};
      PC = 11'h100;
      #1;
      check("jmp_en", enable, 0);
      check("jmp_next", next, 11'h3A7);
      check("jmp_pred", predict_taken, 0);
      tick();

      // Conditional idx 2: table empty so no stall, predicts not-taken.
      set_cond(11'h012, 11'h200);
      #1;
      check("c1_en", enable, 1);
      check("c1_stall", stall, 0);
      check("c1_next", next, 11'h012);
      branch("c1", 11'h012, 11'h200, 1'b1, 1'b0);
      check("c1_pulse", mispredict, 0);
      set_cond(11'h012, 11'h200);
      #1;
      check("c2_next", next, 11'h200);
      branch("c2", 11'h012, 11'h200, 1'b1, 1'b1);

      // Saturation on idx 5: 01 ->10 ->11 ->11 ->11 ->10 ->01 ->00 ->00.
      branch("s1", 11'h015, 11'h155, 1'b1, 1'b0);
      branch("s2", 11'h015, 11'h155, 1'b1, 1'b1);
      branch("s3", 11'h015, 11'h155, 1'b1, 1'b1);
      branch("s4", 11'h015, 11'h155, 1'b1, 1'b1);
      branch("s5", 11'h015, 11'h155, 1'b0, 1'b1);
      branch("s6", 11'h015, 11'h155, 1'b0, 1'b1);
      branch("s7", 11'h015, 11'h155, 1'b0, 1'b0);
      branch("s8", 11'h015, 11'h155, 1'b0, 1'b0);
      branch("s9", 11'h015, 11'h155, 1'b1, 1'b0);
      branch("s10", 11'h015, 11'h155, 1'b1, 1'b0);
      branch("s11", 11'h015, 11'h155, 1'b1, 1'b1);

      // Stall while pending, then resolve and accept in one cycle.
      set_cond(11'h023, 11'h0AA);
      tick();
      set_cond(11'h037, 11'h1BB);
      #1;
      check("st_stall", stall, 1);
      check("st_next", next, 11'h037);
      tick();
      check("st_hold", stall, 1);
      res_valid = 1'b1;
      res_taken = 1'b1;
      #1;
      check("st_rel", stall, 0);
      tick();
      check("st_misp", mispredict, 1);
      check("st_rec", recover_addr, 11'h0AA);
      set_idle();
      res_taken = 1'b0;
      tick();
      res_valid = 1'b0;
      check("st2_misp", mispredict, 0);
      check("st2_rec", recover_addr, 11'h037);
      check("st2_nostall", stall, 0);

      // Same-index resolve and accept: new branch sees pre-update counter.
      set_cond(11'h023, 11'h0AA);
      #1;
      check("si_pred1", predict_taken, 1);
      tick();
      res_valid = 1'b1;
      res_taken = 1'b0;
      #1;
      check("si_pred2", predict_taken, 1);
      check("si_stall", stall, 0);
      tick();
      check("si_misp", mispredict, 1);
      check("si_rec", recover_addr, 11'h023);
      set_idle();
      res_taken = 1'b1;
      tick();
      res_valid = 1'b0;
      check("si2_misp", mispredict, 0);
      tick();
      set_cond(11'h023, 11'h0AA);
      #1;
      check("si_cnt", predict_taken, 1);
      tick();
      set_idle();

      // Reset mid-flight with mispredict high.
      branch("pre", 11'h012, 11'h200, 1'b1, 1'b1);
      set_cond(11'h012, 11'h200);
      tick();
      set_idle();
      res_valid = 1'b1;
      res_taken = 1'b0;
      tick();
      res_valid = 1'b0;
      check("ar_misp_hi", mispredict, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_misp", mispredict, 0);
      check("ar_rec", recover_addr, 0);
      set_cond(11'h012, 11'h200);
      #1;
      check("ar_pred", predict_taken, 0);
      check("ar_stall", stall, 0);
      tick();
      rst_n = 1'b1;
      set_idle();
      res_valid = 1'b1;
      res_taken = 1'b1;
      tick();
      res_valid = 1'b0;
      check("ar_ign", mispredict, 0);
      set_cond(11'h010, 11'h111);
      #1;
      check("ar_tbl", predict_taken, 0);
      check("ar_pv", stall, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
